vec_accum_seq: RTL and testbench

Sequencer that owns one combinational `vec_add` instance and uses it to accumulate a programmed number of input vectors into a single result vector. It sits between the upstream vector producer (ternary matmul-free layer output, residual stream) and the downstream consumer, using valid/ready handshakes on both sides. Arithmetic is element-wise two's-complement with wrap-around, with no saturation, because `vec_add` does not saturate.

---
 rtl/vec_accum_seq.sv | 133 +++++++++++++
 tb/tb_vec_accum_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_accum_seq.sv
// vec_accum_seq: accumulates a programmed number of input vectors into one
// result vector using a single combinational vec_add. The input and output
// sides each use a valid/ready handshake. Lanes are signed fixed-point values
// that wrap on overflow; there is no saturation.

// vec_add: lane-wise two's-complement adder. Each lane wraps modulo 2^FXP_N.
module vec_add #(
    parameter int ARR_WIDTH = 4,
    parameter int FXP_N     = 16
) (
    input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0] in_1,
    input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0] in_2,
    output logic signed [ARR_WIDTH-1:0][FXP_N-1:0] sum_out
);

    // Per-lane sum. The carry out of each lane is dropped, so lanes wrap.
    always_comb begin
        for (int i = 0; i < ARR_WIDTH; i++) begin
            sum_out[i] = in_1[i] + in_2[i];
        end
    end

endmodule

module vec_accum_seq #(
    parameter int ARR_WIDTH = 4,
    parameter int FXP_N     = 16,
    parameter int CNT_W     = 8
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [CNT_W-1:0]                       count,
    output logic                                   busy,
    output logic [CNT_W-1:0]                       beats_left,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0] in_vec,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [ARR_WIDTH-1:0][FXP_N-1:0] out_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [ARR_WIDTH-1:0][FXP_N-1:0] acc;
    logic signed [ARR_WIDTH-1:0][FXP_N-1:0] sum;

    // Datapath controls decoded by the FSM.
    logic job_load;   // clear acc and load the beat counter
    logic beat_take;  // input handshake: fold in_vec into acc

    vec_add #(
        .ARR_WIDTH (ARR_WIDTH),
        .FXP_N     (FXP_N)
    ) u_vec_add (
        .in_1    (acc),
        .in_2    (in_vec),
        .sum_out (sum)
    );

    // State register. A reset mid-job drops the job; no partial result is emitted.
    // NOTE: non-blocking (<=) in clocked blocks, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake outputs. start is acted on only in IDLE.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        job_load  = 1'b0;
        beat_take = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    job_load  = 1'b1;
                    state_nxt = (count == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_take = 1'b1;
                    if (beats_left == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and beat counter. Both hold in DONE and IDLE, so the result
    // stays stable for the whole output stall and remains readable afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            beats_left <= '0;
        end else if (job_load) begin
            acc        <= '0;
            beats_left <= count;
        end else if (beat_take) begin
            acc        <= sum;
            beats_left <= beats_left - CNT_W'(1);
        end
    end

    assign busy    = (state != IDLE);
    assign out_vec = acc;

endmodule

// File: tb/tb_vec_accum_seq.sv
// tb_vec_accum_seq: directed, self-checking bench for vec_accum_seq.
// When a job starts, its expected sum goes into a queue. The bench pops that
// entry and compares it when the output handshake happens.
module tb_vec_accum_seq;

    localparam int A = 4;
    localparam int N = 16;
    localparam int W = 8;

    typedef logic [A-1:0][N-1:0] vec_t;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [W-1:0] count;
    logic         busy;
    logic [W-1:0] beats_left;
    logic         in_valid;
    logic         in_ready;
    vec_t         in_vec;
    logic         out_valid;
    logic         out_ready;
    vec_t         out_vec;

    int   n_vec;
    int   n_err;
    vec_t exp_q[$];

    vec_accum_seq #(
        .ARR_WIDTH (A),
        .FXP_N     (N),
        .CNT_W     (W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .count      (count),
        .busy       (busy),
        .beats_left (beats_left),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t splat(input logic [N-1:0] x);
        vec_t v;
        for (int i = 0; i < A; i++) v[i] = x;
        return v;
    endfunction

    function automatic vec_t vadd(input vec_t a, input vec_t b);
        vec_t v;
        for (int i = 0; i < A; i++) v[i] = N'(a[i] + b[i]);
        return v;
    endfunction

    function automatic vec_t vrand();
        vec_t v;
        for (int i = 0; i < A; i++) v[i] = N'($urandom);
        return v;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t obs, input vec_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] cnt);
        start = 1'b1;
        count = cnt;
        tick();
        start = 1'b0;
    endtask

    // Offer one vector. The block must already be ready; the beat completes at the next edge.
    task automatic feed(input string tag, input vec_t v, input logic [W-1:0] exp_left);
        in_valid = 1'b1;
        in_vec   = v;
        check_bit({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_vec   = vrand();
        check_cnt({tag, "_beats_left"}, beats_left, exp_left);
    endtask

    // Wait (bounded) for out_valid and hold out_ready low for `stall` cycles.
    // Then complete the handshake and check the scoreboard entry.
    task automatic drain(input string tag, input int stall, input logic hold_start);
        vec_t exp;
        int   waited;
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        check_bit({tag, "_out_valid"}, out_valid, 1'b1);
        if (exp_q.size() == 0) begin
            check_bit({tag, "_scoreboard_empty"}, 1'b1, 1'b0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        if (hold_start) begin
            start = 1'b1;
            count = 8'd9;
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            check_bit({tag, "_stall_valid"}, out_valid, 1'b1);
            check_vec({tag, "_stall_vec"}, out_vec, exp);
        end
        out_ready = 1'b1;
        check_vec({tag, "_result"}, out_vec, exp);
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check_bit({tag, "_busy_low"}, busy, 1'b0);
        check_bit({tag, "_valid_low"}, out_valid, 1'b0);
        tick();
        check_bit({tag, "_still_idle"}, busy, 1'b0);
    endtask

    initial begin
        vec_t v [4];
        vec_t exp;
        logic [6:0] pat;
        logic [W-1:0] bl;
        int idx;

        n_vec     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        count     = '0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_vec("rst_out_vec", out_vec, '0);
        check_cnt("rst_beats_left", beats_left, '0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Basic job: 1 + 2 + 3 in every lane, back-to-back
        exp_q.push_back(vadd(vadd(splat(16'd1), splat(16'd2)), splat(16'd3)));
        do_start(8'd3);
        check_bit("basic_busy", busy, 1'b1);
        check_cnt("basic_beats_init", beats_left, 8'd3);
        feed("basic_b1", splat(16'd1), 8'd2);
        feed("basic_b2", splat(16'd2), 8'd1);
        feed("basic_b3", splat(16'd3), 8'd0);
        check_bit("basic_valid_latency", out_valid, 1'b1);
        check_bit("basic_ready_low", in_ready, 1'b0);
        check_vec("basic_six", out_vec, splat(16'd6));
        drain("basic", 0, 1'b0);

        // Upstream stalls (1-0-0-1-1-0-1) and a 5-cycle downstream stall
        for (int i = 0; i < 4; i++) v[i] = vrand();
        exp_q.push_back(vadd(vadd(v[0], v[1]), vadd(v[2], v[3])));
        do_start(8'd4);
        pat = 7'b1011001;
        bl  = 8'd4;
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            in_vec   = pat[i] ? v[idx] : vrand();
            tick();
            if (pat[i]) begin
                idx++;
                bl--;
            end
            in_valid = 1'b0;
            check_cnt("stall_beats_left", beats_left, bl);
        end
        drain("stall", 5, 1'b0);

        // Zero-length job, with start held high through DONE and the output handshake
        exp_q.push_back('0);
        do_start(8'd0);
        check_bit("zero_valid_next", out_valid, 1'b1);
        check_bit("zero_in_ready", in_ready, 1'b0);
        check_cnt("zero_beats_left", beats_left, 8'd0);
        drain("zero", 2, 1'b1);

        // start asserted during ACCUM and DONE has no effect
        v[0] = vrand();
        v[1] = vrand();
        exp_q.push_back(vadd(v[0], v[1]));
        do_start(8'd2);
        start = 1'b1;
        count = 8'd9;
        feed("ign_b1", v[0], 8'd1);
        feed("ign_b2", v[1], 8'd0);
        tick();
        check_cnt("ign_done_beats", beats_left, 8'd0);
        drain("ign", 1, 1'b1);

        // Wrap-around and signed lanes
        v[0] = {16'h8000, 16'h1234, 16'hFFFD, 16'h7FFF};
        v[1] = {16'h8000, 16'h0001, 16'hFFFB, 16'h0001};
        exp  = {16'h0000, 16'h1235, 16'hFFF8, 16'h8000};
        exp_q.push_back(vadd(v[0], v[1]));
        do_start(8'd2);
        feed("wrap_b1", v[0], 8'd1);
        feed("wrap_b2", v[1], 8'd0);
        check_vec("wrap_const", out_vec, exp);
        drain("wrap", 0, 1'b0);

        // Asynchronous reset after 2 of 5 beats, taken between clock edges
        do_start(8'd5);
        feed("rst_b1", vrand(), 8'd4);
        feed("rst_b2", vrand(), 8'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check_bit("amid_busy", busy, 1'b0);
        check_bit("amid_in_ready", in_ready, 1'b0);
        check_bit("amid_out_valid", out_valid, 1'b0);
        check_vec("amid_out_vec", out_vec, '0);
        check_cnt("amid_beats_left", beats_left, '0);
        #2;
        reset_n = 1'b1;
        tick();

        // A fresh single-beat job returns exactly its input
        v[0] = vrand();
        exp_q.push_back(v[0]);
        do_start(8'd1);
        feed("one_b1", v[0], 8'd0);
        drain("one", 0, 1'b0);

        check_bit("scoreboard_drained", exp_q.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
